// File: rtl/mac_drv_pkg.sv
// Shared types and constants for the MAC vector driver.
// Widths and saturation rails of the 14x14->28-bit MAC, plus the driver FSM encoding.
package mac_drv_pkg;

  localparam int A_W = 14;
  localparam int F_W = 28;

  localparam logic [F_W-1:0] SAT_MAX = 28'h7FFFFFF;
  localparam logic [F_W-1:0] SAT_MIN = 28'h8000000;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } drv_state_t;

endpackage

// File: rtl/mac_drv_cnt.sv
// Clearable up-counter with a terminal flag; used for issue and retire counts.
// Ports: clk, reset (sync, active-high), clr, inc, term (count == TERM).
module mac_drv_cnt #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] LIM_V  = W'(TERM + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Stops at TERM+1 so the count can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == TERM_V);

endmodule

// File: rtl/mac_vector_driver.sv
// Sequencer feeding VEC_LEN operand pairs into the saturating MAC and
// returning the captured dot product on a ready/valid result port.
// Ports: in_* operand stream (ready/valid), mac_* MAC drive/return,
//        res_* result stream (ready/valid); res_sat only when
//        MAC_VECTOR_DRIVER_SAT_DETECT_EN is defined.
module mac_vector_driver
  import mac_drv_pkg::*;
#(
  parameter int VEC_LEN = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  output logic           mac_clear,
  output logic           mac_valid_in,
  output logic [A_W-1:0] mac_a,
  output logic [A_W-1:0] mac_b,
  input  logic           mac_valid_out,
  input  logic [F_W-1:0] mac_f,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [F_W-1:0] res_data
`ifdef MAC_VECTOR_DRIVER_SAT_DETECT_EN
  ,
  output logic           res_sat
`endif
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);

  drv_state_t state_q;
  drv_state_t state_d;

  logic accept;
  logic retire;
  logic capture;
  logic issue_term;
  logic retire_term;
  logic cnt_clr;

  logic           mac_valid_in_q;
  logic           mac_valid_in_d;
  logic [A_W-1:0] mac_a_q;
  logic [A_W-1:0] mac_a_d;
  logic [A_W-1:0] mac_b_q;
  logic [A_W-1:0] mac_b_d;
  logic [F_W-1:0] res_data_q;
  logic [F_W-1:0] res_data_d;

  assign accept  = in_valid & in_ready;
  assign cnt_clr = (state_q == S_CLEAR);

  // Returns outside FEED/DRAIN are protocol errors and are dropped.
  assign retire  = mac_valid_out &
                   ((state_q == S_FEED) | (state_q == S_DRAIN));
  assign capture = retire & retire_term;

  mac_drv_cnt #(
    .W    (CNT_W),
    .TERM (VEC_LEN - 1)
  ) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (accept),
    .term  (issue_term)
  );

  mac_drv_cnt #(
    .W    (CNT_W),
    .TERM (VEC_LEN - 1)
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (retire),
    .term  (retire_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (capture) begin
          state_d = S_HOLD;
        end else if (accept && issue_term) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (capture) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_CLEAR;
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mac_clear = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      S_CLEAR: mac_clear = 1'b1;
      S_FEED:  in_ready  = 1'b1;
      S_DRAIN: ;
      S_HOLD:  res_valid = 1'b1;
    endcase
  end

  always_comb begin
    mac_valid_in_d = accept;
    mac_a_d        = accept ? in_a : mac_a_q;
    mac_b_d        = accept ? in_b : mac_b_q;
    res_data_d     = capture ? mac_f : res_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_valid_in_q <= 1'b0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      res_data_q     <= '0;
    end else begin
      mac_valid_in_q <= mac_valid_in_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      res_data_q     <= res_data_d;
    end
  end

  assign mac_valid_in = mac_valid_in_q;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign res_data     = res_data_q;

`ifdef MAC_VECTOR_DRIVER_SAT_DETECT_EN
  logic res_sat_q;
  logic res_sat_d;

  // The MAC pins f to a rail when it saturates.
  always_comb begin
    res_sat_d = res_sat_q;
    if (capture) begin
      res_sat_d = (mac_f == SAT_MAX) | (mac_f == SAT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_sat_q <= 1'b0;
    end else begin
      res_sat_q <= res_sat_d;
    end
  end

  assign res_sat = res_sat_q;
`endif

endmodule
